ctrl_unit: RTL
==============

CTRL_UNIT -- requirements
Module: ctrl_unit

Interface
REQ-001 The block SHALL have no parameters; opcode encodings are fixed by REQ-010.
REQ-002 clk  in  1  single system clock; all state updates occur on its rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset; rst==0 forces the reset state immediately, independent of clk.
REQ-004 Din  in  8  memory data bus: instruction byte or operand byte at the current program-counter address.
REQ-005 ZF  in  1  accumulator-zero flag; CF  in  1  carry flag; both sampled combinationally in DECODE.
REQ-006 IPC  out  1  program-counter increment strobe.
REQ-007 IMPC  out  1  and  IJ  out  1  program-counter load strobes; the program counter loads Din[5:0] when both are 1 and IPC is 0.
REQ-008 IIR  out 1  IR load; IMAR  out 1  MAR load from Din[5:0]; IACC  out 1  accumulator load; IALU  out 1  ALU-to-accumulator select (0 selects memory); ISUB  out 1  ALU subtract; WE  out 1  memory write of the accumulator.
REQ-009 HALT  out  1  level, high while in state HLT; STATE  out  2  current state encoding, for debug.

Function
REQ-010 Opcode = IR[7:4]: 0 NOP, 1 LDA, 2 STA, 3 ADD, 4 SUB, 5 JMP, 6 JZ, 7 JC, F HLT; codes 8..E SHALL decode as NOP.
REQ-011 NOP and HLT are one byte; all other opcodes are two bytes, with the second byte giving the address in [5:0] and [7:6] ignored.
REQ-012 States: FETCH=2'b00, DECODE=2'b01, EXEC=2'b10, HLT=2'b11; STATE SHALL equal the current state.
REQ-013 The internal 8-bit IR SHALL load Din on the clock edge ending FETCH and SHALL otherwise hold.
REQ-014 FETCH: assert IIR=1 and IPC=1; next state is DECODE.
REQ-015 DECODE with NOP or 8..E: assert no strobes; next state is FETCH.
REQ-016 DECODE with HLT: assert no strobes; next state is HLT.
REQ-017 DECODE with a taken jump (JMP; JZ with ZF=1; JC with CF=1): assert IMPC=1, IJ=1, IPC=0; next state is FETCH.
REQ-018 DECODE with an untaken jump: assert IPC=1 only, which skips the operand; next state is FETCH.
REQ-019 DECODE with LDA, STA, ADD or SUB: assert IMAR=1 and IPC=1; next state is EXEC.
REQ-020 EXEC behaviour by opcode:
- LDA: IACC=1, IALU=0.
- STA: WE=1.
- ADD: IACC=1, IALU=1, ISUB=0.
- SUB: IACC=1, IALU=1, ISUB=1.
- Next state is FETCH in every case.
REQ-021 HLT: assert no strobes and HALT=1; remain in HLT until rst.
REQ-022 All strobes SHALL be combinational from state, IR and flags; unlisted strobes are 0 in each state.
REQ-023 IPC and IMPC SHALL never both be 1 in the same cycle; IMPC and IJ SHALL always be equal.
REQ-024 Cycle counts: one-byte instruction = 2 cycles; jump = 2 cycles; memory or ALU instruction = 3 cycles.
REQ-025 Flags SHALL be evaluated only in DECODE; flag changes in other states have no effect.

Reset
REQ-026 While rst==0:
- state=FETCH, IR=8'h00;
- every strobe output, HALT and STATE SHALL be 0 (strobes gated by rst).
REQ-027 Reset asserted mid-instruction (in DECODE, EXEC or HLT) SHALL abort the instruction with no further strobes.
REQ-028 The first FETCH strobes SHALL appear in the first cycle after rst rises.

Verification
REQ-029 Reset, then memory 00:8'h13, 01:8'h2A -> FETCH IIR/IPC; DECODE IMAR/IPC; EXEC IACC=1, IALU=0; back to FETCH after 3 cycles.
REQ-030 JZ 8'h60, operand 8'h05, ZF=1 -> DECODE IMPC=IJ=1, IPC=0; with ZF=0 -> IPC=1 only; both cases return to FETCH.
REQ-031 Byte 8'h4x with operand -> EXEC IACC=1, IALU=1, ISUB=1; 8'h2x -> EXEC WE=1, IACC=0.
REQ-032 8'hF0 -> HALT=1 and STATE=2'b11 held for 20 cycles with all strobes 0; rst pulse -> STATE=00 asynchronously.
REQ-033 rst=0 applied mid-EXEC between clock edges -> strobes drop to 0 immediately; after release, a fetch begins with IR reloaded.
REQ-034 A random instruction stream of 1000 instructions -> assertion checks REQ-023 every cycle and that opcodes 8..E behave as NOP.

Source files
------------

// File: rtl/ctrl_unit.sv
// ---------------------------------------------------------------------------
// ctrl_unit -- control sequencer for a small accumulator machine.
//
// Sequences FETCH -> DECODE -> (EXEC) -> FETCH. The HLT opcode parks the
// machine in HLT until reset. Every strobe is combinational from the current
// state, the instruction register and the flags, and all strobes are gated
// off while reset is asserted.
//
// Ports
//   clk    in   1  system clock, rising-edge active
//   rst    in   1  asynchronous reset, active low
//   Din    in   8  memory data bus (instruction or operand byte)
//   ZF     in   1  accumulator-zero flag, only looked at in DECODE
//   CF     in   1  carry flag, only looked at in DECODE
//   IPC    out  1  program-counter increment
//   IMPC   out  1  program-counter load (paired with IJ)
//   IJ     out  1  program-counter load (paired with IMPC)
//   IIR    out  1  instruction-register load
//   IMAR   out  1  MAR load from Din[5:0]
//   IACC   out  1  accumulator load
//   IALU   out  1  accumulator source: 1 = ALU, 0 = memory
//   ISUB   out  1  ALU subtract
//   WE     out  1  memory write of the accumulator
//   HALT   out  1  high while halted
//   STATE  out  2  current state encoding (debug)
// ---------------------------------------------------------------------------
module ctrl_unit (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] Din,
   input  logic       ZF,
   input  logic       CF,
   output logic       IPC,
   output logic       IMPC,
   output logic       IJ,
   output logic       IIR,
   output logic       IMAR,
   output logic       IACC,
   output logic       IALU,
   output logic       ISUB,
   output logic       WE,
   output logic       HALT,
   output logic [1:0] STATE
);

   typedef enum logic [1:0] {
      S_FETCH  = 2'b00,
      S_DECODE = 2'b01,
      S_EXEC   = 2'b10,
      S_HLT    = 2'b11
   } state_t;

   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_STA = 4'h2;
   localparam logic [3:0] OP_ADD = 4'h3;
   localparam logic [3:0] OP_SUB = 4'h4;
   localparam logic [3:0] OP_JMP = 4'h5;
   localparam logic [3:0] OP_JZ  = 4'h6;
   localparam logic [3:0] OP_JC  = 4'h7;
   localparam logic [3:0] OP_HLT = 4'hF;

   state_t     state_reg;
   state_t     state_next;
   logic [7:0] ir_reg;
   logic [3:0] opcode;
   logic       jump_taken;

   assign opcode = ir_reg[7:4];

   // Only meaningful while opcode is one of the jumps and the state is DECODE.
   assign jump_taken = (opcode == OP_JMP)
                     | ((opcode == OP_JZ) & ZF)
                     | ((opcode == OP_JC) & CF);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= S_FETCH;
         ir_reg    <= 8'h00;
      end else begin
         state_reg <= state_next;
         if (state_reg == S_FETCH)
            ir_reg <= Din;
      end
   end

   always_comb begin
      state_next = state_reg;
      IPC  = 1'b0;
      IMPC = 1'b0;
      IJ   = 1'b0;
      IIR  = 1'b0;
      IMAR = 1'b0;
      IACC = 1'b0;
      IALU = 1'b0;
      ISUB = 1'b0;
      WE   = 1'b0;
      HALT = 1'b0;

      case (state_reg)
         S_FETCH: begin
            IIR        = 1'b1;
            IPC        = 1'b1;
            state_next = S_DECODE;
         end
         S_DECODE: begin
            state_next = S_FETCH;
            case (opcode)
               OP_LDA, OP_STA, OP_ADD, OP_SUB: begin
                  IMAR       = 1'b1;
                  IPC        = 1'b1;
                  state_next = S_EXEC;
               end
               OP_JMP, OP_JZ, OP_JC: begin
                  // A taken jump loads the PC from the operand byte; an
                  // untaken one just steps the PC past the operand.
                  if (jump_taken) begin
                     IMPC = 1'b1;
                     IJ   = 1'b1;
                  end else begin
                     IPC  = 1'b1;
                  end
               end
               OP_HLT:  state_next = S_HLT;
               default: ;  // NOP and the unused codes 8..E
            endcase
         end
         S_EXEC: begin
            state_next = S_FETCH;
            case (opcode)
               OP_LDA: IACC = 1'b1;
               OP_STA: WE   = 1'b1;
               OP_ADD: begin
                  IACC = 1'b1;
                  IALU = 1'b1;
               end
               OP_SUB: begin
                  IACC = 1'b1;
                  IALU = 1'b1;
                  ISUB = 1'b1;
               end
               default: ;
            endcase
         end
         S_HLT: HALT = 1'b1;
         default: state_next = S_FETCH;
      endcase

      // Strobes are combinational, so the state register being forced to
      // FETCH is not enough: gate everything directly on reset.
      if (!rst) begin
         IPC  = 1'b0;
         IMPC = 1'b0;
         IJ   = 1'b0;
         IIR  = 1'b0;
         IMAR = 1'b0;
         IACC = 1'b0;
         IALU = 1'b0;
         ISUB = 1'b0;
         WE   = 1'b0;
         HALT = 1'b0;
      end
   end

   assign STATE = state_reg;

endmodule
